rvh_tlb_flush_ctrl: RTL and testbench

- Sequences an SFENCE.VMA-style shootdown across the DTLB and ITLB.
- Gates new TLB miss requests toward the shared MMU/PTW port and drains in-flight page walks.
- Issues the flush to both TLBs, collects both grants, and signals completion.
- Sits between the TLB miss outputs and rvh_mmu/rvh_tlb_arbiter, and replaces direct wiring of the per-TLB flush ports.

---
 rtl/rvh_tlb_flush_ctrl_if.sv | 63 ++++++
 rtl/rvh_tlb_flush_ctrl.sv | 115 +++++++++++
 tb/tb_rvh_tlb_flush_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rvh_tlb_flush_ctrl_if.sv
// Bundle between the shootdown controller and its surroundings: sfence request,
// per-TLB miss gating, per-TLB flush handshake and the shared flush payload.
interface rvh_tlb_flush_ctrl_if #(
    parameter int unsigned VPN_WIDTH  = 27,
    parameter int unsigned ASID_WIDTH = 16
) ();
    logic                  sfence_req_vld_i;
    logic                  sfence_req_use_asid_i;
    logic                  sfence_req_use_vpn_i;
    logic [VPN_WIDTH-1:0]  sfence_req_vpn_i;
    logic [ASID_WIDTH-1:0] sfence_req_asid_i;
    logic                  sfence_req_rdy_o;
    logic                  sfence_done_o;

    logic                  dtlb_miss_req_vld_i;
    logic                  dtlb_miss_req_vld_o;
    logic                  dtlb_miss_req_rdy_i;
    logic                  dtlb_miss_resp_vld_i;
    logic                  itlb_miss_req_vld_i;
    logic                  itlb_miss_req_vld_o;
    logic                  itlb_miss_req_rdy_i;
    logic                  itlb_miss_resp_vld_i;

    logic                  dtlb_flush_vld_o;
    logic                  dtlb_flush_grant_i;
    logic                  itlb_flush_vld_o;
    logic                  itlb_flush_grant_i;
    logic                  flush_use_asid_o;
    logic                  flush_use_vpn_o;
    logic [VPN_WIDTH-1:0]  flush_vpn_o;
    logic [ASID_WIDTH-1:0] flush_asid_o;
    logic                  miss_block_o;

    // Controller side.
    modport slave (
        input  sfence_req_vld_i, sfence_req_use_asid_i, sfence_req_use_vpn_i,
        input  sfence_req_vpn_i, sfence_req_asid_i,
        output sfence_req_rdy_o, sfence_done_o,
        input  dtlb_miss_req_vld_i, dtlb_miss_req_rdy_i, dtlb_miss_resp_vld_i,
        output dtlb_miss_req_vld_o,
        input  itlb_miss_req_vld_i, itlb_miss_req_rdy_i, itlb_miss_resp_vld_i,
        output itlb_miss_req_vld_o,
        output dtlb_flush_vld_o, itlb_flush_vld_o,
        input  dtlb_flush_grant_i, itlb_flush_grant_i,
        output flush_use_asid_o, flush_use_vpn_o, flush_vpn_o, flush_asid_o,
        output miss_block_o
    );

    // Environment side (TLBs, MMU, sfence source).
    modport master (
        output sfence_req_vld_i, sfence_req_use_asid_i, sfence_req_use_vpn_i,
        output sfence_req_vpn_i, sfence_req_asid_i,
        input  sfence_req_rdy_o, sfence_done_o,
        output dtlb_miss_req_vld_i, dtlb_miss_req_rdy_i, dtlb_miss_resp_vld_i,
        input  dtlb_miss_req_vld_o,
        output itlb_miss_req_vld_i, itlb_miss_req_rdy_i, itlb_miss_resp_vld_i,
        input  itlb_miss_req_vld_o,
        input  dtlb_flush_vld_o, itlb_flush_vld_o,
        output dtlb_flush_grant_i, itlb_flush_grant_i,
        input  flush_use_asid_o, flush_use_vpn_o, flush_vpn_o, flush_asid_o,
        input  miss_block_o
    );
endinterface

// File: rtl/rvh_tlb_flush_ctrl.sv
// SFENCE.VMA shootdown sequencer: blocks new TLB misses, drains in-flight walks,
// flushes DTLB and ITLB, collects both grants and pulses done.
module rvh_tlb_flush_ctrl #(
    parameter int unsigned VPN_WIDTH       = 27,
    parameter int unsigned ASID_WIDTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rstn,
    rvh_tlb_flush_ctrl_if.slave bus
);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  dcnt_q, dcnt_d;
    logic [CNT_WIDTH-1:0]  icnt_q, icnt_d;
    logic                  dgnt_q, ignt_q;
    logic                  block_q, done_q;
    logic                  use_asid_q, use_vpn_q;
    logic [VPN_WIDTH-1:0]  vpn_q;
    logic [ASID_WIDTH-1:0] asid_q;

    logic d_hs, i_hs, accept;
    logic d_fvld, i_fvld, d_gnt_now, i_gnt_now;

    // Saturating up/down count; simultaneous inc and dec cancel.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic inc, input logic dec);
        logic [CNT_WIDTH-1:0] r;
        r = cnt;
        if (inc && !dec && (cnt != CNT_MAX))
            r = cnt + CNT_WIDTH'(1);
        else if (dec && !inc && (cnt != '0))
            r = cnt - CNT_WIDTH'(1);
        return r;
    endfunction

    always_comb begin
        d_hs      = bus.dtlb_miss_req_vld_i & ~block_q & bus.dtlb_miss_req_rdy_i;
        i_hs      = bus.itlb_miss_req_vld_i & ~block_q & bus.itlb_miss_req_rdy_i;
        accept    = bus.sfence_req_vld_i & (state_q == IDLE);
        dcnt_d    = cnt_next(dcnt_q, d_hs, bus.dtlb_miss_resp_vld_i);
        icnt_d    = cnt_next(icnt_q, i_hs, bus.itlb_miss_resp_vld_i);
        d_fvld    = (state_q == FLUSH) & ~dgnt_q;
        i_fvld    = (state_q == FLUSH) & ~ignt_q;
        d_gnt_now = dgnt_q | (bus.dtlb_flush_grant_i & d_fvld);
        i_gnt_now = ignt_q | (bus.itlb_flush_grant_i & i_fvld);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            dcnt_q     <= '0;
            icnt_q     <= '0;
            dgnt_q     <= 1'b0;
            ignt_q     <= 1'b0;
            block_q    <= 1'b0;
            done_q     <= 1'b0;
            use_asid_q <= 1'b0;
            use_vpn_q  <= 1'b0;
            vpn_q      <= '0;
            asid_q     <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            icnt_q <= icnt_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        use_asid_q <= bus.sfence_req_use_asid_i;
                        use_vpn_q  <= bus.sfence_req_use_vpn_i;
                        vpn_q      <= bus.sfence_req_vpn_i;
                        asid_q     <= bus.sfence_req_asid_i;
                        block_q    <= 1'b1;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((dcnt_d == '0) && (icnt_d == '0))
                        state_q <= FLUSH;
                end
                FLUSH: begin
                    dgnt_q <= d_gnt_now;
                    ignt_q <= i_gnt_now;
                    if (d_gnt_now && i_gnt_now) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    block_q <= 1'b0;
                    dgnt_q  <= 1'b0;
                    ignt_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sfence_req_rdy_o    = (state_q == IDLE);
    assign bus.sfence_done_o       = done_q;
    assign bus.miss_block_o        = block_q;
    assign bus.dtlb_miss_req_vld_o = bus.dtlb_miss_req_vld_i & ~block_q;
    assign bus.itlb_miss_req_vld_o = bus.itlb_miss_req_vld_i & ~block_q;
    assign bus.dtlb_flush_vld_o    = d_fvld;
    assign bus.itlb_flush_vld_o    = i_fvld;
    assign bus.flush_use_asid_o    = use_asid_q;
    assign bus.flush_use_vpn_o     = use_vpn_q;
    assign bus.flush_vpn_o         = vpn_q;
    assign bus.flush_asid_o        = asid_q;
endmodule

// File: tb/tb_rvh_tlb_flush_ctrl.sv
// Directed vector bench for rvh_tlb_flush_ctrl: one record per clock cycle with
// hand-computed outputs, plus hand-written multi-cycle corner sequences.
module tb_rvh_tlb_flush_ctrl;
    logic clk;
    logic rstn;

    rvh_tlb_flush_ctrl_if #(.VPN_WIDTH(27), .ASID_WIDTH(16)) bus ();

    rvh_tlb_flush_ctrl #(.VPN_WIDTH(27), .ASID_WIDTH(16), .MAX_OUTSTANDING(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sf   = {vld, use_asid, use_vpn}
    // miss = {d_vld, d_rdy, d_resp, i_vld, i_rdy, i_resp}
    // gnt  = {d_grant, i_grant}
    // exp  = {rdy, done, block, d_miss_vld_o, i_miss_vld_o, d_flush_vld, i_flush_vld}
    typedef struct {
        string       nm;
        logic        rstn;
        logic [2:0]  sf;
        logic [26:0] vpn;
        logic [15:0] asid;
        logic [5:0]  miss;
        logic [1:0]  gnt;
        logic [6:0]  exp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   mark_a;

    function automatic vec_t mk(input string nm, input logic [2:0] sf, input logic [5:0] miss,
                                input logic [1:0] gnt, input logic [6:0] exp,
                                input logic r = 1'b1, input logic [26:0] vpn = 27'h0,
                                input logic [15:0] asid = 16'h0);
        vec_t v;
        v.nm = nm; v.rstn = r; v.sf = sf; v.vpn = vpn; v.asid = asid;
        v.miss = miss; v.gnt = gnt; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge, check just after.
    task automatic apply(input vec_t v);
        logic [6:0] act;
        @(negedge clk);
        rstn                      = v.rstn;
        bus.sfence_req_vld_i      = v.sf[2];
        bus.sfence_req_use_asid_i = v.sf[1];
        bus.sfence_req_use_vpn_i  = v.sf[0];
        bus.sfence_req_vpn_i      = v.vpn;
        bus.sfence_req_asid_i     = v.asid;
        bus.dtlb_miss_req_vld_i   = v.miss[5];
        bus.dtlb_miss_req_rdy_i   = v.miss[4];
        bus.dtlb_miss_resp_vld_i  = v.miss[3];
        bus.itlb_miss_req_vld_i   = v.miss[2];
        bus.itlb_miss_req_rdy_i   = v.miss[1];
        bus.itlb_miss_resp_vld_i  = v.miss[0];
        bus.dtlb_flush_grant_i    = v.gnt[1];
        bus.itlb_flush_grant_i    = v.gnt[0];
        #1;
        act = {bus.sfence_req_rdy_o, bus.sfence_done_o, bus.miss_block_o,
               bus.dtlb_miss_req_vld_o, bus.itlb_miss_req_vld_o,
               bus.dtlb_flush_vld_o, bus.itlb_flush_vld_o};
        total++;
        if (act !== v.exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (rdy,done,blk,dmiss,imiss,dflush,iflush)",
                     v.nm, act, v.exp);
        end
    endtask

    task automatic chk_payload(input string nm, input logic ua, input logic uv,
                               input logic [26:0] vpn, input logic [15:0] asid);
        logic [44:0] act;
        logic [44:0] want;
        act  = {bus.flush_use_asid_o, bus.flush_use_vpn_o, bus.flush_vpn_o, bus.flush_asid_o};
        want = {ua, uv, vpn, asid};
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (use_asid,use_vpn,vpn,asid)", nm, act, want);
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.sfence_req_vld_i = 1'b0; bus.sfence_req_use_asid_i = 1'b0;
        bus.sfence_req_use_vpn_i = 1'b0; bus.sfence_req_vpn_i = '0; bus.sfence_req_asid_i = '0;
        bus.dtlb_miss_req_vld_i = 1'b0; bus.dtlb_miss_req_rdy_i = 1'b0; bus.dtlb_miss_resp_vld_i = 1'b0;
        bus.itlb_miss_req_vld_i = 1'b0; bus.itlb_miss_req_rdy_i = 1'b0; bus.itlb_miss_resp_vld_i = 1'b0;
        bus.dtlb_flush_grant_i = 1'b0; bus.itlb_flush_grant_i = 1'b0;

        // Idle flush with ASID 5, both grants on the first FLUSH cycle.
        tbl.push_back(mk("a_idle",   3'b000, 6'b000000, 2'b00, 7'b1000000));
        tbl.push_back(mk("a_accept", 3'b110, 6'b000000, 2'b00, 7'b1000000, 1'b1, 27'h0, 16'h5));
        tbl.push_back(mk("a_drain",  3'b000, 6'b000000, 2'b00, 7'b0010000));
        tbl.push_back(mk("a_flush",  3'b000, 6'b000000, 2'b11, 7'b0010011));
        tbl.push_back(mk("a_done",   3'b000, 6'b000000, 2'b00, 7'b0110000));
        tbl.push_back(mk("a_rdy",    3'b000, 6'b100100, 2'b00, 7'b1001100));
        mark_a = tbl.size();
        // Drain two DTLB misses; miss requests stay gated throughout.
        tbl.push_back(mk("b_hs0",    3'b000, 6'b110000, 2'b00, 7'b1001000));
        tbl.push_back(mk("b_hs1",    3'b000, 6'b110000, 2'b00, 7'b1001000));
        tbl.push_back(mk("b_accept", 3'b100, 6'b100000, 2'b00, 7'b1001000));
        tbl.push_back(mk("b_t1",     3'b000, 6'b110000, 2'b00, 7'b0010000));
        tbl.push_back(mk("b_t2",     3'b000, 6'b110000, 2'b00, 7'b0010000));
        tbl.push_back(mk("b_t3",     3'b000, 6'b111000, 2'b00, 7'b0010000));
        tbl.push_back(mk("b_t4",     3'b000, 6'b110000, 2'b00, 7'b0010000));
        tbl.push_back(mk("b_t5",     3'b000, 6'b110000, 2'b00, 7'b0010000));
        tbl.push_back(mk("b_t6",     3'b000, 6'b111000, 2'b00, 7'b0010000));
        tbl.push_back(mk("b_t7",     3'b000, 6'b110000, 2'b00, 7'b0010011));
        tbl.push_back(mk("b_t8",     3'b000, 6'b110000, 2'b11, 7'b0010011));
        tbl.push_back(mk("b_t9",     3'b000, 6'b000000, 2'b00, 7'b0110000));
        tbl.push_back(mk("b_t10",    3'b000, 6'b000000, 2'b00, 7'b1000000));
        // Miss handshake in the accept cycle is counted and drained.
        tbl.push_back(mk("c_accept", 3'b100, 6'b110000, 2'b00, 7'b1001000));
        tbl.push_back(mk("c_t1",     3'b000, 6'b000000, 2'b00, 7'b0010000));
        tbl.push_back(mk("c_t2",     3'b000, 6'b000000, 2'b00, 7'b0010000));
        tbl.push_back(mk("c_t3",     3'b000, 6'b001000, 2'b00, 7'b0010000));
        tbl.push_back(mk("c_t4",     3'b000, 6'b000000, 2'b11, 7'b0010011));
        tbl.push_back(mk("c_t5",     3'b000, 6'b000000, 2'b00, 7'b0110000));
        tbl.push_back(mk("c_t6",     3'b000, 6'b000000, 2'b00, 7'b1000000));

        repeat (3) @(posedge clk);
        apply(mk("reset", 3'b000, 6'b000000, 2'b00, 7'b1000000));
        chk_payload("reset_payload", 1'b0, 1'b0, 27'h0, 16'h0);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            if (i == mark_a - 1)
                chk_payload("a_payload", 1'b1, 1'b0, 27'h0, 16'h5);
        end

        // Staggered grants; grants during DRAIN must be ignored.
        apply(mk("s_accept", 3'b101, 6'b000000, 2'b00, 7'b1000000, 1'b1, 27'h1234567, 16'hBEEF));
        apply(mk("s_drain",  3'b000, 6'b000000, 2'b11, 7'b0010000));
        apply(mk("s_f0",     3'b000, 6'b000000, 2'b01, 7'b0010011));
        apply(mk("s_f1",     3'b000, 6'b000000, 2'b01, 7'b0010010));
        apply(mk("s_f2",     3'b000, 6'b000000, 2'b00, 7'b0010010));
        apply(mk("s_f3",     3'b000, 6'b000000, 2'b10, 7'b0010010));
        apply(mk("s_done",   3'b000, 6'b000000, 2'b00, 7'b0110000));
        chk_payload("s_payload", 1'b0, 1'b1, 27'h1234567, 16'hBEEF);
        apply(mk("s_idle",   3'b000, 6'b000000, 2'b00, 7'b1000000));

        // Response with empty counters must not underflow.
        apply(mk("u_resp",   3'b000, 6'b001001, 2'b00, 7'b1000000));
        apply(mk("u_accept", 3'b100, 6'b000000, 2'b00, 7'b1000000));
        apply(mk("u_drain",  3'b000, 6'b000000, 2'b00, 7'b0010000));
        apply(mk("u_flush",  3'b000, 6'b000000, 2'b11, 7'b0010011));
        apply(mk("u_done",   3'b000, 6'b000000, 2'b00, 7'b0110000));
        apply(mk("u_idle",   3'b000, 6'b000000, 2'b00, 7'b1000000));

        // ITLB handshake plus simultaneous handshake/response leaves count at 1.
        apply(mk("m_hs",     3'b000, 6'b000110, 2'b00, 7'b1000100));
        apply(mk("m_both",   3'b000, 6'b000111, 2'b00, 7'b1000100));
        apply(mk("m_accept", 3'b100, 6'b000000, 2'b00, 7'b1000000));
        apply(mk("m_drain",  3'b000, 6'b000000, 2'b00, 7'b0010000));
        apply(mk("m_resp",   3'b000, 6'b000001, 2'b00, 7'b0010000));
        apply(mk("m_flush",  3'b000, 6'b000000, 2'b11, 7'b0010011));
        apply(mk("m_done",   3'b000, 6'b000000, 2'b00, 7'b0110000));
        apply(mk("m_idle",   3'b000, 6'b000000, 2'b00, 7'b1000000));

        // Five DTLB handshakes saturate at 4, so four responses drain it.
        for (int k = 0; k < 5; k++)
            apply(mk($sformatf("sat_hs%0d", k), 3'b000, 6'b110000, 2'b00, 7'b1001000));
        apply(mk("sat_accept", 3'b100, 6'b000000, 2'b00, 7'b1000000));
        for (int k = 0; k < 4; k++)
            apply(mk($sformatf("sat_resp%0d", k), 3'b000, 6'b001000, 2'b00, 7'b0010000));
        apply(mk("sat_flush",  3'b000, 6'b000000, 2'b11, 7'b0010011));
        apply(mk("sat_done",   3'b000, 6'b000000, 2'b00, 7'b0110000));
        apply(mk("sat_idle",   3'b000, 6'b000000, 2'b00, 7'b1000000));

        // Reset during FLUSH after the DTLB grant abandons the flush.
        apply(mk("r_accept", 3'b111, 6'b000000, 2'b00, 7'b1000000, 1'b1, 27'h7ABCDEF, 16'h1234));
        apply(mk("r_drain",  3'b000, 6'b000000, 2'b00, 7'b0010000));
        apply(mk("r_f0",     3'b000, 6'b000000, 2'b10, 7'b0010011));
        apply(mk("r_f1",     3'b000, 6'b000000, 2'b00, 7'b0010001, 1'b0));
        apply(mk("r_after",  3'b000, 6'b000000, 2'b00, 7'b1000000));
        chk_payload("r_payload", 1'b0, 1'b0, 27'h0, 16'h0);
        apply(mk("r_after2", 3'b000, 6'b000000, 2'b00, 7'b1000000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
